// File: rtl/pc_gen_if.sv
// Fetch-PC bundle between pc_gen (master) and the fetch stage / redirect sources (slave).
// dbg_state mirrors pc_gen's FSM state for observation only.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            redir_valid;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] pc_ex;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] trap_vec;
  logic            fetch_ready;
  logic            pc_valid;
  logic [XLEN-1:0] pc_out;
  logic            misalign;
  logic [XLEN-1:0] bad_addr;
  logic [1:0]      dbg_state;

  // Handshake: a fetch is accepted in any cycle where pc_valid & fetch_ready;
  // pc_out must not change while pc_valid=1 and fetch_ready=0, and pc_valid
  // never drops once raised except through reset.
  modport master (
    input  redir_valid, pc_sel, pc_ex, rs1_value, imm, trap_vec, fetch_ready,
    output pc_valid, pc_out, misalign, bad_addr, dbg_state
  );

  modport slave (
    output redir_valid, pc_sel, pc_ex, rs1_value, imm, trap_vec, fetch_ready,
    input  pc_valid, pc_out, misalign, bad_addr, dbg_state
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator with redirect/pending-target handling.
// Optional macro PC_GEN_MISALIGN_TRAP_EN: misaligned targets divert to trap_vec and pulse misalign.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 4
) (
  input  logic    clk,
  input  logic    rst,
  pc_gen_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [XLEN-1:0] raw_tgt;
  logic [XLEN-1:0] tgt;
  logic            pc_valid;
  logic            hs;

  always_comb begin
    raw_tgt = '0;
    case (bus.pc_sel)
      2'b00:   raw_tgt = bus.pc_ex + STEP;
      2'b01:   raw_tgt = bus.pc_ex + bus.imm;
      2'b10:   raw_tgt = (bus.rs1_value + bus.imm) & ~XLEN'(1);
      default: raw_tgt = bus.trap_vec;
    endcase
  end

`ifdef PC_GEN_MISALIGN_TRAP_EN
  logic            mis;
  logic            misalign_q;
  logic [XLEN-1:0] bad_addr_q;

  assign mis = |(raw_tgt & ALIGN_MASK);
  assign tgt = mis ? bus.trap_vec : raw_tgt;

  // Pulse is raised for any redirect, whether it is taken immediately or parked as pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      misalign_q <= bus.redir_valid & mis;
      bad_addr_q <= (bus.redir_valid & mis) ? raw_tgt : '0;
    end
  end

  assign bus.misalign = misalign_q;
  assign bus.bad_addr = bad_addr_q;
`else
  assign tgt          = raw_tgt & ~ALIGN_MASK;
  assign bus.misalign = 1'b0;
  assign bus.bad_addr = '0;
`endif

  assign pc_valid = (state_q != BOOT);
  assign hs       = pc_valid & bus.fetch_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    case (state_q)
      BOOT: begin
        // A redirect seen during BOOT waits for the first accepted fetch.
        state_d = RUN;
        if (bus.redir_valid) begin
          pend_d     = tgt;
          pend_vld_d = 1'b1;
        end
      end
      default: begin
        if (hs) begin
          if (bus.redir_valid)  pc_d = tgt;
          else if (pend_vld_q)  pc_d = pend_q;
          else                  pc_d = pc_q + STEP;
          pend_vld_d = 1'b0;
          state_d    = RUN;
        end else if (bus.redir_valid) begin
          pend_d     = tgt;
          pend_vld_d = 1'b1;
          state_d    = HOLD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign bus.pc_valid  = pc_valid;
  assign bus.pc_out    = pc_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomized scoreboard bench for pc_gen: a fetch-stream model predicts every
// accepted fetch address and every misalign pulse; a negedge monitor checks them.
module tb_pc_gen;
  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam int          IALIGN    = 4;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } mis_t;

  logic clk;
  logic rst;
  int unsigned cyc;

  pc_gen_if #(.XLEN(XLEN)) bus_if ();

  pc_gen #(.XLEN(XLEN), .RESET_VEC(RESET_VEC), .IALIGN(IALIGN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  mis_t        mis_q[$];
  int          n_vec;
  int          n_err;
  bit          chk_en;
  bit          exp_valid;
  bit          exp_boot;

  // Fetch-stream model: address presented next, and the youngest redirect not yet consumed.
  logic [31:0] m_cur;
  logic [31:0] m_pend;
  bit          m_pend_v;
  bit          m_booted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] raw_target(input logic [1:0] s, input logic [31:0] pcex,
                                             input logic [31:0] rs1, input logic [31:0] imm,
                                             input logic [31:0] trap);
    case (s)
      2'd0:    return pcex + IALIGN;
      2'd1:    return pcex + imm;
      2'd2:    return (rs1 + imm) & 32'hFFFF_FFFE;
      default: return trap;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic drv(input bit r, input bit rv, input logic [1:0] s, input logic [31:0] pcex,
                     input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] trap,
                     input bit fr);
    logic [31:0] raw;
    logic [31:0] tgt;
    bit          hs;
    rst                = r;
    bus_if.redir_valid = rv;
    bus_if.pc_sel      = s;
    bus_if.pc_ex       = pcex;
    bus_if.rs1_value   = rs1;
    bus_if.imm         = imm;
    bus_if.trap_vec    = trap;
    bus_if.fetch_ready = fr;
    if (r) begin
      exp_q.delete();
      mis_q.delete();
      m_cur     = RESET_VEC;
      m_pend_v  = 1'b0;
      m_booted  = 1'b0;
      chk_en    = 1'b0;
      exp_valid = 1'b0;
      exp_boot  = 1'b0;
    end else begin
      chk_en    = 1'b1;
      exp_valid = m_booted;
      exp_boot  = !m_booted;
      tgt       = '0;
      if (rv) begin
        raw = raw_target(s, pcex, rs1, imm, trap);
        if ((raw % IALIGN) != 0) begin
`ifdef PC_GEN_MISALIGN_TRAP_EN
          tgt = trap;
          mis_q.push_back('{due: cyc + 1, addr: raw});
`else
          tgt = raw - (raw % IALIGN);
`endif
        end else begin
          tgt = raw;
        end
      end
      hs = m_booted && fr;
      if (hs) begin
        exp_q.push_back(m_cur);
        if (rv)            m_cur = tgt;
        else if (m_pend_v) m_cur = m_pend;
        else               m_cur = m_cur + IALIGN;
        m_pend_v = 1'b0;
      end else if (rv) begin
        m_pend   = tgt;
        m_pend_v = 1'b1;
      end
      m_booted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit fr);
    drv(1'b0, 1'b0, 2'd0, $urandom, $urandom, $urandom, $urandom, fr);
  endtask

  task automatic do_reset();
    drv(1'b1, 1'b0, 2'd0, '0, '0, '0, '0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_valid", {31'd0, bus_if.pc_valid}, {31'd0, exp_valid});
      if (exp_boot) begin
        check("boot_pc_out", bus_if.pc_out, RESET_VEC);
        check("boot_misalign", {31'd0, bus_if.misalign}, 32'd0);
        check("boot_bad_addr", bus_if.bad_addr, 32'd0);
      end
      if (bus_if.pc_valid && bus_if.fetch_ready) begin
        if (exp_q.size() == 0) check("unexpected_fetch", bus_if.pc_out, 32'hDEAD_BEEF);
        else                   check("fetch_pc", bus_if.pc_out, exp_q.pop_front());
      end
`ifdef PC_GEN_MISALIGN_TRAP_EN
      if (mis_q.size() > 0 && mis_q[0].due < cyc) begin
        check("missed_misalign", {31'd0, bus_if.misalign}, 32'd1);
        void'(mis_q.pop_front());
      end
      if (bus_if.misalign) begin
        if (mis_q.size() == 0 || mis_q[0].due != cyc) begin
          check("spurious_misalign", {31'd0, bus_if.misalign}, 32'd0);
        end else begin
          check("bad_addr", bus_if.bad_addr, mis_q[0].addr);
          void'(mis_q.pop_front());
        end
      end
`else
      check("misalign_tied", {31'd0, bus_if.misalign}, 32'd0);
      check("bad_addr_tied", bus_if.bad_addr, 32'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec    = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    m_cur    = RESET_VEC;
    m_pend   = '0;
    m_pend_v = 1'b0;
    m_booted = 1'b0;
    do_reset();
    do_reset();

    // Boot then free-running fetch: 0, 4, 8.
    repeat (4) idle(1'b1);

    // Land on 0x100, stall with a pc_ex+imm redirect, then release -> 0x100, 0x130.
    drv(1'b0, 1'b1, 2'd1, 32'h100, 32'h0, 32'h0, 32'h0, 1'b1);
    drv(1'b0, 1'b1, 2'd1, 32'h0F0, 32'h0, 32'h40, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Two redirects while stalled: the younger (0x800) wins.
    drv(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'h200, 1'b0);
    drv(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'h800, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Misaligned jalr-style target.
    drv(1'b0, 1'b1, 2'd2, 32'h0, 32'h1003, 32'h0, 32'h400, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Wrap from the top of the address space.
    drv(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset in HOLD with pending 0x300: the pending target must never appear.
    drv(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'h300, 1'b0);
    idle(1'b0);
    do_reset();
    repeat (4) idle(1'b1);

    // Redirect during BOOT is applied at the first accepted fetch.
    do_reset();
    drv(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 32'h500, 1'b1);
    repeat (3) idle(1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drv(1'b0,
            $urandom_range(0, 3) == 0,
            2'($urandom_range(0, 3)),
            $urandom & 32'hFFFF_FFFC,
            $urandom,
            32'($urandom_range(0, 511)) - 32'd256,
            $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 2) != 0);
      end
    end

    // Drain: let any outstanding misalign pulse retire.
    repeat (3) idle(1'b0);
    chk_en = 1'b0;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("mis_q_drained", 32'(mis_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and operand width.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have parameter IALIGN, default 4, instruction alignment in bytes (2 or 4).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port redir_valid  in  1  control-flow redirect request.
REQ-008 SHALL have port pc_sel  in  2  target select: 00 sequential, 01 pc_ex+imm, 10 (rs1_value+imm)&~1, 11 trap_vec.
REQ-009 SHALL have port pc_ex  in  XLEN  PC of the redirecting instruction.
REQ-010 SHALL have port rs1_value  in  XLEN  register rs1 value.
REQ-011 SHALL have port imm  in  XLEN  sign-extended immediate.
REQ-012 SHALL have port trap_vec  in  XLEN  trap handler address.
REQ-013 SHALL have port fetch_ready  in  1  fetch stage accepts pc_out.
REQ-014 SHALL have port pc_valid  out  1  pc_out is a valid fetch address.
REQ-015 SHALL have port pc_out  out  XLEN  current fetch PC.
REQ-016 SHALL have port misalign  out  1  one-cycle misaligned-target pulse.
REQ-017 SHALL have port bad_addr  out  XLEN  offending target, valid while misalign=1.

Function
REQ-018 SHALL implement FSM states BOOT, RUN, HOLD.
REQ-019 BOOT: pc_valid=0, pc_out=RESET_VEC; next cycle goes to RUN unconditionally.
REQ-020 RUN/HOLD: pc_valid=1; handshake occurs when pc_valid & fetch_ready.
REQ-021 SHALL keep pc_out stable while pc_valid=1 and fetch_ready=0.
REQ-022 Target computation SHALL be modulo 2^XLEN with carries discarded; pc_sel=00 with redir_valid=1 SHALL mean pc_ex+IALIGN.
REQ-023 No redirect, handshake: pc_out <= pc_out+IALIGN at the next edge (1-cycle latency).
REQ-024 Redirect with fetch_ready=1 (RUN): pc_out <= target at the next edge.
REQ-025 Redirect with fetch_ready=0: target SHALL be latched into a pending register, and the FSM SHALL enter HOLD.
REQ-026 HOLD: a new redirect SHALL overwrite the pending target (youngest wins).
REQ-027 HOLD with handshake: pc_out <= pending target (or the same-cycle redirect target if redir_valid=1), then RUN.
REQ-028 Operands SHALL be sampled only in the redirect cycle; later operand changes SHALL not alter a pending target.
REQ-029 pc_out SHALL wrap from 2^XLEN-IALIGN to 0 without error.
REQ-030 Redirect during BOOT SHALL be latched as pending and applied on the first RUN handshake.

Reset
REQ-031 When rst=1 at the clock edge, the block SHALL set state=BOOT, pc_out=RESET_VEC, pc_valid=0, misalign=0, bad_addr=0, and clear pending.
REQ-032 Reset SHALL take priority over every redirect and handshake, including mid-HOLD.

Configuration
REQ-033 Macro PC_GEN_MISALIGN_TRAP_EN defined: a redirect target with target mod IALIGN != 0 SHALL be replaced by trap_vec, and the block SHALL pulse misalign=1 for one cycle with bad_addr=raw target in the cycle after the redirect is taken or latched.
REQ-034 Macro undefined: the target's low log2(IALIGN) bits SHALL be forced to zero, and misalign and bad_addr SHALL be tied 0.

Verification
REQ-035 Reset then fetch_ready=1 for 4 cycles -> pc_valid 0,1,1,1; pc_out 0,0,4,8.
REQ-036 pc_out=0x100, fetch_ready=0 with redirect pc_sel=01, pc_ex=0x0F0, imm=0x40 -> pc_out holds 0x100; after fetch_ready=1, pc_out=0x130.
REQ-037 HOLD pending 0x200, second redirect pc_sel=11, trap_vec=0x800 while stalled -> after the handshake pc_out=0x800.
REQ-038 pc_sel=10, rs1_value=0x1003, imm=0 -> macro defined: pc_out=trap_vec, misalign=1, bad_addr=0x1002; macro undefined: pc_out=0x1000, misalign=0.
REQ-039 pc_out=0xFFFF_FFFC, handshake -> pc_out=0x0000_0000.
REQ-040 rst asserted in HOLD with pending 0x300 -> pc_out=RESET_VEC; the pending target is never issued.
